// File: rtl/vec_mem_unit.sv
// ---------------------------------------------------------------------------
// vec_mem_unit
//   Multi-cycle load/store engine for the vector execute stage. Moves a whole
//   vector (NUM_ELEM elements) or a single scalar between the register files
//   and a single-port synchronous data memory with 1-cycle read latency.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   mem_st      start request; only honoured in IDLE
//   mem_op      10 load vector, 11 load scalar, 00 store vector, 01 store scalar
//   addr        base address of the transfer
//   vec_wdata   vector store data, element k at [k*ELEM_W +: ELEM_W]
//   esc_wdata   scalar store data
//   mem_rdy     1 in DONE, or in IDLE with no start pending
//   vec_rdata   vector load result (held until the next vector load)
//   esc_rdata   scalar load result (held until the next scalar load)
//   dmem_addr   data memory address, 0 outside issue cycles
//   dmem_we     data memory write enable
//   dmem_wdata  data memory write data, 0 outside write cycles
//   dmem_rdata  data memory read data, valid the cycle after its address
// ---------------------------------------------------------------------------
module vec_mem_unit #(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 4,
  parameter int ADDR_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_st,
  input  logic [1:0]                   mem_op,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [NUM_ELEM*ELEM_W-1:0]   vec_wdata,
  input  logic [ELEM_W-1:0]            esc_wdata,
  output logic                         mem_rdy,
  output logic [NUM_ELEM*ELEM_W-1:0]   vec_rdata,
  output logic [ELEM_W-1:0]            esc_rdata,
  output logic [ADDR_W-1:0]            dmem_addr,
  output logic                         dmem_we,
  output logic [ELEM_W-1:0]            dmem_wdata,
  input  logic [ELEM_W-1:0]            dmem_rdata
);

  localparam int VEC_W = NUM_ELEM * ELEM_W;
  localparam int CNT_W = $clog2(NUM_ELEM + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_VEC  = CNT_W'(NUM_ELEM);

  // Pick element idx out of a packed vector.
  function automatic logic [ELEM_W-1:0] elem_sel(input logic [VEC_W-1:0] v,
                                                 input logic [CNT_W-1:0] idx);
    logic [ELEM_W-1:0] r;
    r = {ELEM_W{1'b0}};
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (idx == CNT_W'(k)) begin
        r = v[k*ELEM_W +: ELEM_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Replace element idx of a packed vector with e.
  function automatic logic [VEC_W-1:0] elem_put(input logic [VEC_W-1:0]  v,
                                                input logic [CNT_W-1:0]  idx,
                                                input logic [ELEM_W-1:0] e);
    logic [VEC_W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (idx == CNT_W'(k)) begin
        r[k*ELEM_W +: ELEM_W] = e;
      end else begin
        r[k*ELEM_W +: ELEM_W] = v[k*ELEM_W +: ELEM_W];
      end
    end
    return r;
  endfunction

  logic [1:0]        state_r,      state_s;
  logic              scalar_r,     scalar_s;
  logic [ADDR_W-1:0] base_r,       base_s;
  logic [VEC_W-1:0]  vwd_r,        vwd_s;
  logic [ELEM_W-1:0] ewd_r,        ewd_s;
  logic [CNT_W-1:0]  n_r,          n_s;
  logic [CNT_W-1:0]  cnt_r,        cnt_s;
  logic [VEC_W-1:0]  vec_rdata_r,  vec_rdata_s;
  logic [ELEM_W-1:0] esc_rdata_r,  esc_rdata_s;
  logic [ADDR_W-1:0] dmem_addr_r,  dmem_addr_s;
  logic              dmem_we_r,    dmem_we_s;
  logic [ELEM_W-1:0] dmem_wdata_r, dmem_wdata_s;

  // Ready is combinational so processor control sees completion in DONE itself.
  assign mem_rdy    = (state_r == ST_DONE) || ((state_r == ST_IDLE) && !mem_st);
  assign vec_rdata  = vec_rdata_r;
  assign esc_rdata  = esc_rdata_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_wdata = dmem_wdata_r;

  // FSM next state, operand latching, element counter and read-data capture.
  // In RD, cnt_r counts cycles 0..n: cycles 0..n-1 issue address base+cnt,
  // cycles 1..n capture the element issued in the previous cycle.
  always_comb begin
    state_s     = state_r;
    scalar_s    = scalar_r;
    base_s      = base_r;
    vwd_s       = vwd_r;
    ewd_s       = ewd_r;
    n_s         = n_r;
    cnt_s       = cnt_r;
    vec_rdata_s = vec_rdata_r;
    esc_rdata_s = esc_rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_st) begin
          scalar_s = mem_op[0];
          base_s   = addr;
          vwd_s    = vec_wdata;
          ewd_s    = esc_wdata;
          n_s      = mem_op[0] ? CNT_ONE : CNT_VEC;
          cnt_s    = CNT_ZERO;
          state_s  = mem_op[1] ? ST_RD : ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_r != CNT_ZERO) begin
          if (scalar_r) begin
            esc_rdata_s = dmem_rdata;
          end else begin
            vec_rdata_s = elem_put(vec_rdata_r, cnt_r - CNT_ONE, dmem_rdata);
          end
        end else begin
          vec_rdata_s = vec_rdata_r;
        end
        if (cnt_r == n_r) begin
          state_s = ST_DONE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WR: begin
        if (cnt_r == (n_r - CNT_ONE)) begin
          state_s = ST_DONE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Memory port values for the next cycle, derived from the next state so the
  // port can be registered without adding a cycle of latency.
  always_comb begin
    dmem_we_s    = 1'b0;
    dmem_addr_s  = {ADDR_W{1'b0}};
    dmem_wdata_s = {ELEM_W{1'b0}};
    case (state_s)
      ST_WR: begin
        dmem_we_s    = 1'b1;
        dmem_addr_s  = base_s + ADDR_W'(cnt_s);
        dmem_wdata_s = scalar_s ? ewd_s : elem_sel(vwd_s, cnt_s);
      end
      ST_RD: begin
        if (cnt_s < n_s) begin
          dmem_addr_s = base_s + ADDR_W'(cnt_s);
        end else begin
          dmem_addr_s = {ADDR_W{1'b0}};
        end
      end
      ST_IDLE: begin
        dmem_we_s = 1'b0;
      end
      ST_DONE: begin
        dmem_we_s = 1'b0;
      end
      default: begin
        dmem_we_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also aborts any write in flight and
  // clears partially captured load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      scalar_r     <= 1'b0;
      base_r       <= {ADDR_W{1'b0}};
      vwd_r        <= {VEC_W{1'b0}};
      ewd_r        <= {ELEM_W{1'b0}};
      n_r          <= CNT_ZERO;
      cnt_r        <= CNT_ZERO;
      vec_rdata_r  <= {VEC_W{1'b0}};
      esc_rdata_r  <= {ELEM_W{1'b0}};
      dmem_addr_r  <= {ADDR_W{1'b0}};
      dmem_we_r    <= 1'b0;
      dmem_wdata_r <= {ELEM_W{1'b0}};
    end else begin
      state_r      <= state_s;
      scalar_r     <= scalar_s;
      base_r       <= base_s;
      vwd_r        <= vwd_s;
      ewd_r        <= ewd_s;
      n_r          <= n_s;
      cnt_r        <= cnt_s;
      vec_rdata_r  <= vec_rdata_s;
      esc_rdata_r  <= esc_rdata_s;
      dmem_addr_r  <= dmem_addr_s;
      dmem_we_r    <= dmem_we_s;
      dmem_wdata_r <= dmem_wdata_s;
    end
  end

endmodule

// File: tb/tb_vec_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_unit
//   Directed self-checking bench for vec_mem_unit. A behavioural single-port
//   memory with 1-cycle read latency sits on the dmem_* port. Inputs change
//   1 time unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_vec_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_st = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [31:0] vec_wdata = 32'h0;
  logic [7:0]  esc_wdata = 8'h00;
  logic        mem_rdy;
  logic [31:0] vec_rdata;
  logic [7:0]  esc_rdata;
  logic [7:0]  dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;

  logic [7:0]  tb_mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;
  int lo;
  logic [7:0] tr_addr [0:31];
  logic       tr_we   [0:31];
  logic [7:0] tr_wd   [0:31];

  vec_mem_unit #(.ELEM_W(8), .NUM_ELEM(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .mem_st(mem_st), .mem_op(mem_op), .addr(addr),
    .vec_wdata(vec_wdata), .esc_wdata(esc_wdata), .mem_rdy(mem_rdy),
    .vec_rdata(vec_rdata), .esc_rdata(esc_rdata), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: write on we, read data one cycle later.
  always @(posedge clk) begin
    if (dmem_we) tb_mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= tb_mem[dmem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one operation from IDLE, scramble the inputs after the accept edge,
  // and trace the memory port until mem_rdy rises (DONE). lo = cycles low.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a,
                       input logic [31:0] vw, input logic [7:0] ew);
    mem_op = op; addr = a; vec_wdata = vw; esc_wdata = ew; mem_st = 1'b1;
    #1;
    lo = 0;
    while (mem_rdy !== 1'b1 && lo < 32) begin
      tr_addr[lo] = dmem_addr; tr_we[lo] = dmem_we; tr_wd[lo] = dmem_wdata;
      lo++;
      step();
      if (lo == 1) begin
        mem_st = 1'b0; addr = ~a; vec_wdata = ~vw; esc_wdata = ~ew; mem_op = ~op;
        #1;
      end
    end
    n_cmp++; if (lo >= 32) begin n_bad++; $display("FAIL op_timeout: mem_rdy still %b after %0d cycles, required 1", mem_rdy, lo); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (mem_rdy !== 1'b1)       begin n_bad++; $display("FAIL rst_mem_rdy: got %b want 1", mem_rdy); end
    n_cmp++; if (dmem_we !== 1'b0)       begin n_bad++; $display("FAIL rst_we: got %b want 0", dmem_we); end
    n_cmp++; if (dmem_addr !== 8'h00)    begin n_bad++; $display("FAIL rst_addr: got %h want 00", dmem_addr); end
    n_cmp++; if (dmem_wdata !== 8'h00)   begin n_bad++; $display("FAIL rst_wdata: got %h want 00", dmem_wdata); end
    n_cmp++; if (vec_rdata !== 32'h0)    begin n_bad++; $display("FAIL rst_vec: got %h want 0", vec_rdata); end
    n_cmp++; if (esc_rdata !== 8'h00)    begin n_bad++; $display("FAIL rst_esc: got %h want 00", esc_rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_vec_load();
    logic [7:0] ea;
    logic       we_any;
    do_op(2'b10, 8'h10, 32'h0, 8'h00);
    n_cmp++; if (lo !== 6) begin n_bad++; $display("FAIL vload_latency: got %0d want 6", lo); end
    for (int k = 0; k < 4; k++) begin
      ea = 8'h10 + 8'(k);
      n_cmp++; if (tr_addr[k+1] !== ea) begin n_bad++; $display("FAIL vload_addr%0d: got %h want %h", k, tr_addr[k+1], ea); end
    end
    n_cmp++; if (tr_addr[5] !== 8'h00) begin n_bad++; $display("FAIL vload_addr_idle: got %h want 00", tr_addr[5]); end
    we_any = 1'b0;
    for (int k = 0; k < 6; k++) we_any = we_any | tr_we[k];
    n_cmp++; if (we_any !== 1'b0) begin n_bad++; $display("FAIL vload_we: got %b want 0", we_any); end
    n_cmp++; if (vec_rdata !== 32'h44332211) begin n_bad++; $display("FAIL vload_data: got %h want 44332211", vec_rdata); end
    step();
    n_cmp++; if (mem_rdy !== 1'b1) begin n_bad++; $display("FAIL vload_idle_rdy: got %b want 1", mem_rdy); end
  endtask

  task automatic test_vec_store();
    logic [31:0] vw;
    logic [7:0]  eb;
    logic [7:0]  ea;
    vw = 32'hDDCCBBAA;
    do_op(2'b00, 8'h20, vw, 8'h00);
    n_cmp++; if (lo !== 5) begin n_bad++; $display("FAIL vstore_latency: got %0d want 5", lo); end
    n_cmp++; if (tr_we[0] !== 1'b0) begin n_bad++; $display("FAIL vstore_we_accept: got %b want 0", tr_we[0]); end
    for (int k = 0; k < 4; k++) begin
      eb = vw[k*8 +: 8];
      ea = 8'h20 + 8'(k);
      n_cmp++; if (tr_we[k+1] !== 1'b1) begin n_bad++; $display("FAIL vstore_we%0d: got %b want 1", k, tr_we[k+1]); end
      n_cmp++; if (tr_addr[k+1] !== ea) begin n_bad++; $display("FAIL vstore_addr%0d: got %h want %h", k, tr_addr[k+1], ea); end
      n_cmp++; if (tr_wd[k+1] !== eb)   begin n_bad++; $display("FAIL vstore_wd%0d: got %h want %h", k, tr_wd[k+1], eb); end
      n_cmp++; if (tb_mem[ea] !== eb)   begin n_bad++; $display("FAIL vstore_mem%0d: got %h want %h", k, tb_mem[ea], eb); end
    end
    step();
    do_op(2'b10, 8'h20, 32'h0, 8'h00);
    n_cmp++; if (vec_rdata !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL vstore_readback: got %h want DDCCBBAA", vec_rdata); end
    step();
  endtask

  task automatic test_scalar();
    do_op(2'b01, 8'h05, 32'h0, 8'h7E);
    n_cmp++; if (lo !== 2) begin n_bad++; $display("FAIL sstore_latency: got %0d want 2", lo); end
    n_cmp++; if (tr_we[1] !== 1'b1)     begin n_bad++; $display("FAIL sstore_we: got %b want 1", tr_we[1]); end
    n_cmp++; if (tr_addr[1] !== 8'h05)  begin n_bad++; $display("FAIL sstore_addr: got %h want 05", tr_addr[1]); end
    n_cmp++; if (tr_wd[1] !== 8'h7E)    begin n_bad++; $display("FAIL sstore_wd: got %h want 7E", tr_wd[1]); end
    n_cmp++; if (tb_mem[8'h05] !== 8'h7E) begin n_bad++; $display("FAIL sstore_mem: got %h want 7E", tb_mem[8'h05]); end
    n_cmp++; if (tb_mem[8'h06] !== 8'h00) begin n_bad++; $display("FAIL sstore_single: got %h want 00", tb_mem[8'h06]); end
    step();
    do_op(2'b11, 8'h05, 32'h0, 8'h00);
    n_cmp++; if (lo !== 3) begin n_bad++; $display("FAIL sload_latency: got %0d want 3", lo); end
    n_cmp++; if (tr_addr[1] !== 8'h05)     begin n_bad++; $display("FAIL sload_addr: got %h want 05", tr_addr[1]); end
    n_cmp++; if (esc_rdata !== 8'h7E)      begin n_bad++; $display("FAIL sload_data: got %h want 7E", esc_rdata); end
    n_cmp++; if (vec_rdata !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL sload_vec_kept: got %h want DDCCBBAA", vec_rdata); end
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] wa [0:3];
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
    do_op(2'b10, 8'hFE, 32'h0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (tr_addr[k+1] !== wa[k]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", k, tr_addr[k+1], wa[k]); end
    end
    n_cmp++; if (vec_rdata !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL wrap_data: got %h want D4C3B2A1", vec_rdata); end
    step();
  endtask

  // mem_st held high across two scalar stores; inputs change mid-op.
  task automatic test_back_to_back();
    mem_op = 2'b01; addr = 8'h30; esc_wdata = 8'h5A; mem_st = 1'b1;
    #1;
    n_cmp++; if (mem_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_rdy: got %b want 0", mem_rdy); end
    step();
    addr = 8'h40; esc_wdata = 8'h99;
    #1;
    n_cmp++; if (dmem_we !== 1'b1)     begin n_bad++; $display("FAIL b2b_wr1_we: got %b want 1", dmem_we); end
    n_cmp++; if (dmem_addr !== 8'h30)  begin n_bad++; $display("FAIL b2b_wr1_addr: got %h want 30", dmem_addr); end
    n_cmp++; if (dmem_wdata !== 8'h5A) begin n_bad++; $display("FAIL b2b_wr1_wd: got %h want 5A", dmem_wdata); end
    step();
    n_cmp++; if (mem_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_done_rdy: got %b want 1", mem_rdy); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_done_we: got %b want 0", dmem_we); end
    step();
    n_cmp++; if (mem_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_accept2_rdy: got %b want 0", mem_rdy); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_accept2_we: got %b want 0", dmem_we); end
    step();
    mem_st = 1'b0;
    #1;
    n_cmp++; if (dmem_we !== 1'b1)     begin n_bad++; $display("FAIL b2b_wr2_we: got %b want 1", dmem_we); end
    n_cmp++; if (dmem_addr !== 8'h40)  begin n_bad++; $display("FAIL b2b_wr2_addr: got %h want 40", dmem_addr); end
    n_cmp++; if (dmem_wdata !== 8'h99) begin n_bad++; $display("FAIL b2b_wr2_wd: got %h want 99", dmem_wdata); end
    step();
    n_cmp++; if (mem_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_done2_rdy: got %b want 1", mem_rdy); end
    n_cmp++; if (tb_mem[8'h30] !== 8'h5A) begin n_bad++; $display("FAIL b2b_mem30: got %h want 5A", tb_mem[8'h30]); end
    n_cmp++; if (tb_mem[8'h40] !== 8'h99) begin n_bad++; $display("FAIL b2b_mem40: got %h want 99", tb_mem[8'h40]); end
    step();
  endtask

  // Reset is sampled on the edge that would start the second write cycle.
  task automatic test_reset_mid_store();
    mem_op = 2'b00; addr = 8'h50; vec_wdata = 32'h87654321; mem_st = 1'b1;
    step();
    mem_st = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (dmem_we !== 1'b1) begin n_bad++; $display("FAIL rstwr_first_we: got %b want 1", dmem_we); end
    step();
    n_cmp++; if (dmem_we !== 1'b0)     begin n_bad++; $display("FAIL rstwr_we: got %b want 0", dmem_we); end
    n_cmp++; if (dmem_addr !== 8'h00)  begin n_bad++; $display("FAIL rstwr_addr: got %h want 00", dmem_addr); end
    n_cmp++; if (dmem_wdata !== 8'h00) begin n_bad++; $display("FAIL rstwr_wd: got %h want 00", dmem_wdata); end
    n_cmp++; if (mem_rdy !== 1'b1)     begin n_bad++; $display("FAIL rstwr_rdy: got %b want 1", mem_rdy); end
    n_cmp++; if (vec_rdata !== 32'h0)  begin n_bad++; $display("FAIL rstwr_vec: got %h want 0", vec_rdata); end
    n_cmp++; if (esc_rdata !== 8'h00)  begin n_bad++; $display("FAIL rstwr_esc: got %h want 00", esc_rdata); end
    rst = 1'b0;
    step(); step();
    n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL rstwr_idle_we: got %b want 0", dmem_we); end
    n_cmp++; if (tb_mem[8'h50] !== 8'h21) begin n_bad++; $display("FAIL rstwr_mem50: got %h want 21", tb_mem[8'h50]); end
    n_cmp++; if (tb_mem[8'h51] !== 8'h00) begin n_bad++; $display("FAIL rstwr_mem51: got %h want 00", tb_mem[8'h51]); end
    n_cmp++; if (tb_mem[8'h52] !== 8'h00) begin n_bad++; $display("FAIL rstwr_mem52: got %h want 00", tb_mem[8'h52]); end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) tb_mem[k] = 8'h00;
    tb_mem[8'h10] = 8'h11; tb_mem[8'h11] = 8'h22; tb_mem[8'h12] = 8'h33; tb_mem[8'h13] = 8'h44;
    tb_mem[8'hFE] = 8'hA1; tb_mem[8'hFF] = 8'hB2; tb_mem[8'h00] = 8'hC3; tb_mem[8'h01] = 8'hD4;
    test_reset();
    test_vec_load();
    test_vec_store();
    test_scalar();
    test_wrap();
    test_back_to_back();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vec_mem_unit.md
Name: vec_mem_unit

Overview:
- Multi-cycle load/store engine for the vector processor's execute stage.
- Driven by the decode-stage memory start and 2-bit memory op from processor control; reports completion back to processor control on mem_rdy.
- Moves whole vectors (NUM_ELEM elements) or single scalars between the register files and a single-port synchronous data memory with 1-cycle read latency.
- Load results feed the vector register write mux (VEC_MEM input) and the scalar register write mux (ESC_MEM input).

Parameters:
ELEM_W, 8, element/scalar width in bits
NUM_ELEM, 4, elements per vector (>=2)
ADDR_W, 8, data memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_st  in  1  start request (cl_mem_st)
mem_op  in  2  10 load vector, 11 load scalar, 00 store vector, 01 store scalar
addr  in  ADDR_W  base address
vec_wdata  in  NUM_ELEM*ELEM_W  vector store data
esc_wdata  in  ELEM_W  scalar store data
mem_rdy  out  1  unit idle/complete
vec_rdata  out  NUM_ELEM*ELEM_W  vector load result
esc_rdata  out  ELEM_W  scalar load result
dmem_addr  out  ADDR_W  memory address
dmem_we  out  1  memory write enable
dmem_wdata  out  ELEM_W  memory write data
dmem_rdata  in  ELEM_W  memory read data, valid the cycle after its address

Behaviour:
- Clocking: single clock clk; rst is synchronous, active-high.
- Reset: state IDLE, counters 0, vec_rdata 0, esc_rdata 0, dmem_we 0, dmem_addr 0, dmem_wdata 0. mem_rdy is 1 after reset (IDLE with mem_st low).
- States: IDLE, RD, WR, DONE.
- Accept: only in IDLE with mem_st=1.
  - Latch mem_op, addr, vec_wdata, esc_wdata.
  - Set element count n = NUM_ELEM for vector ops, 1 for scalar ops.
  - Next state is RD for loads (mem_op[1]=1) and WR for stores.
  - mem_st outside IDLE is ignored; latched operands do not change mid-operation.
- mem_rdy is combinational: 1 in DONE, or in IDLE with mem_st=0; 0 otherwise (including the accept cycle).
- RD:
  - Issue counter i drives dmem_addr = base+i for i < n.
  - Capture counter j stores dmem_rdata one cycle after each issue.
  - Element k goes to vec_rdata[k*ELEM_W +: ELEM_W]; element 0 is at the base address.
  - Scalar load writes esc_rdata only; vec_rdata is untouched.
  - RD lasts exactly n+1 cycles, then DONE.
- WR:
  - Each cycle: dmem_we=1, dmem_addr = base+i, dmem_wdata = element i (or esc_wdata for a scalar store).
  - WR lasts exactly n cycles, then DONE. No read-data capture.
- DONE: exactly 1 cycle, then IDLE unconditionally. Any mem_st seen in DONE is not accepted; it is accepted in the following IDLE cycle if still high.
- Output hold rules:
  - Outside active issue cycles: dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - vec_rdata/esc_rdata hold their last value until overwritten by a later load's capture.
  - Results are partially updated during RD; they are valid once mem_rdy=1.
- Address arithmetic is modulo 2^ADDR_W; wrap from all-ones to 0 is legal and not flagged.
- Latency, accept edge to mem_rdy=1:
  - vector load NUM_ELEM+2 cycles
  - scalar load 3 cycles
  - vector store NUM_ELEM+1 cycles
  - scalar store 2 cycles
- rst in any state: return to IDLE next edge and apply the reset values above. Any in-flight write is aborted (dmem_we=0 from that edge on); partially captured load data is cleared.

Test Plan:
1. Vector load: memory[0x10..0x13] = 11,22,33,44; mem_st, op=10, addr=0x10 -> dmem_addr 0x10..0x13 on consecutive cycles; vec_rdata=0x44332211; mem_rdy low 6 cycles, then high 1 cycle in DONE.
2. Vector store: op=00, addr=0x20, vec_wdata=0xDDCCBBAA -> dmem_we high 4 cycles writing AA,BB,CC,DD to 0x20..0x23; read-back via op=10 returns 0xDDCCBBAA.
3. Scalar ops: op=01, addr=0x05, esc_wdata=0x7E -> single write; then op=11, addr=0x05 -> esc_rdata=0x7E, vec_rdata unchanged, mem_rdy low exactly 3 cycles.
4. Wrap-around: vector load at addr=0xFE -> addresses FE,FF,00,01 in order, data packed element0=[FE].
5. Start while busy/DONE: hold mem_st high for consecutive ops -> second op accepted only in the IDLE cycle after DONE; the first op's latched operands are unaffected by input changes mid-op.
6. Reset mid-store: assert rst in the 2nd WR cycle of a vector store -> dmem_we=0 next edge, state IDLE, mem_rdy=1, vec_rdata=0, esc_rdata=0, only 1 element written.
